gray_stream_gen: RTL

- Sequential Gray-code source: a binary up/down counter plus a registered Gray encoding of it, presented on a valid/ready stream.
- Sits directly upstream of the binary-to-Gray conversion path. It produces a monotonic binary count (bin_out) and its Gray equivalent (gray_out) for pointer and position consumers.
- gray_out is encoded in-block, so downstream sees a glitch-free registered code.

---
 rtl/gray_stream_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gray_stream_gen.sv
// gray_stream_gen: binary up/down counter with a registered Gray encoding,
// presented on a valid/ready output stream.
//
// Stream handshake: a word transfers on any rising edge where
// out_valid && out_ready. out_valid is high only in RUN. While out_valid is
// high and out_ready is low, bin_out/gray_out hold. The count advances by one
// only on a transfer.
//
// Optional build macro GRAY_STEP_CHECK_EN adds step_err. step_err is a
// one-cycle pulse flagging an accepted Gray word that is not exactly one bit
// away from the previously accepted word in the same RUN session.
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = RUN, 2 = DONE).
module gray_stream_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir_up,
  input  logic             wrap_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             done,
`ifdef GRAY_STEP_CHECK_EN
  output logic             step_err,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  state_t           state_q;
  state_t           state_n;
  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] step_val;
  logic             handshake;
  logic             at_term;

  // Gray code of a binary value: top bit copied, every other bit is the XOR
  // of itself with its upper neighbour.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  assign handshake = (state_q == S_RUN) && out_ready;
  assign at_term   = dir_up ? (bin_out == ALL_ONES) : (bin_out == ALL_ZERO);
  assign step_val  = dir_up ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));

  // Next-state and next-count decode. Load and start can coincide outside RUN.
  // In RUN, stop wins over the terminal move to DONE.
  always_comb begin
    state_n = state_q;
    bin_n   = bin_out;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          bin_n = load_val;
        end
        if (start) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (handshake) begin
          if (at_term && !wrap_en) begin
            state_n = S_DONE;
          end else begin
            bin_n = step_val;
          end
        end
        if (stop) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, count and Gray code all register on the same edge. This keeps
  // bin_out and gray_out consistent with each other on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bin_out  <= '0;
      gray_out <= '0;
    end else begin
      state_q  <= state_n;
      bin_out  <= bin_n;
      gray_out <= to_gray(bin_n);
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] last_gray;
  logic             last_ok;

  function automatic int ones(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  // Remember the last accepted Gray word and flag a non-unit step. A load or
  // start outside RUN begins a new session, so the next word is not compared.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gray <= '0;
      last_ok   <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      step_err <= 1'b0;
      if ((state_q != S_RUN) && (load || start)) begin
        last_ok <= 1'b0;
      end else if (handshake) begin
        step_err  <= last_ok && (ones(gray_out ^ last_gray) != 1);
        last_gray <= gray_out;
        last_ok   <= 1'b1;
      end
    end
  end
`endif

endmodule
